ifetch_queue: RTL and testbench

- Fetch-side bus master and prefetch buffer, directly downstream of the PC register stage.
- Consumes the current instruction address and issues one instruction-bus read at a time.
- Queues each returned word with its PC in a small FIFO for decode.
- Pulses pc_incr_o back to the PC stage whenever a request is granted, so the PC advances exactly once per accepted fetch.

---
 rtl/ifetch_queue_if.sv | 45 ++++
 rtl/ifetch_queue.sv | 89 ++++++++
 tb/tb_ifetch_queue.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - PC-stage, instruction-bus and decode-side signals of the fetch queue
interface ifetch_queue_if;
  logic [31:0] inst_addr_i;
  logic        pc_incr_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  modport master (
    input  inst_addr_i,
    output pc_incr_o,
    output bus_req_o,
    output bus_addr_o,
    input  bus_gnt_i,
    input  bus_rvalid_i,
    input  bus_rdata_i,
    input  flush_i,
    output id_valid_o,
    output id_instr_o,
    output id_pc_o,
    input  id_ready_i
  );

  modport slave (
    output inst_addr_i,
    input  pc_incr_o,
    input  bus_req_o,
    input  bus_addr_o,
    output bus_gnt_i,
    output bus_rvalid_i,
    output bus_rdata_i,
    output flush_i,
    input  id_valid_o,
    input  id_instr_o,
    input  id_pc_o,
    output id_ready_i
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - single-outstanding instruction fetch master with a PC-tagged prefetch FIFO
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [1:0]     S_IDLE  = 2'd0;
  localparam logic [1:0]     S_REQ   = 2'd1;
  localparam logic [1:0]     S_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   addr_q;
  logic          discard;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          push;
  logic          pop;

  assign push = (state == S_WAIT) && bus.bus_rvalid_i && !discard && !bus.flush_i;
  assign pop  = (count != '0) && bus.id_ready_i;

  assign bus.bus_req_o  = (state == S_REQ);
  assign bus.bus_addr_o = addr_q;
  assign bus.pc_incr_o  = (state == S_REQ) && bus.bus_gnt_i && !discard && !bus.flush_i;
  assign bus.id_valid_o = (count != '0);
  assign bus.id_instr_o = mem_instr[rd_ptr];
  assign bus.id_pc_o    = mem_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= RESET_PC;
      discard <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= RESET_PC;
      end
    end else begin
      case (state)
        // A request is launched only with a free slot, so the later push always fits.
        S_IDLE: begin
          if (!bus.flush_i && count < DEPTH_C) begin
            addr_q <= bus.inst_addr_i;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.flush_i) discard <= 1'b1;
          if (bus.bus_gnt_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.bus_rvalid_i) begin
            discard <= 1'b0;
            state   <= S_IDLE;
          end else if (bus.flush_i) begin
            discard <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (bus.flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          mem_instr[wr_ptr] <= bus.bus_rdata_i;
          mem_pc[wr_ptr]    <= addr_q;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized scoreboard bench for ifetch_queue with a PC-stage and bus model
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  ifetch_queue_if ifc ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int total = 0;
  int bad   = 0;
  entry_t      sb[$];
  logic [31:0] req_log[$];
  logic [31:0] pc;
  logic [31:0] cur_addr;
  logic [31:0] flush_target;
  logic [31:0] rdata_val;
  bit in_req, in_wait, cur_dirty;
  bit fixed_rdata, force_flush, flush_on_rv, flush_at3, late_rv;
  int gnt_wait, rv_wait;
  int gnt_min, gnt_max, rv_min, rv_max, flush_pct, ready_pct;
  int pops, incr_cnt, gnt_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs at +1, monitor compares at +2, model advances at +3.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rst) begin
      check("rst_bus_req", 32'(ifc.bus_req_o), 0);
      check("rst_pc_incr", 32'(ifc.pc_incr_o), 0);
      check("rst_id_valid", 32'(ifc.id_valid_o), 0);
      check("rst_bus_addr", ifc.bus_addr_o, RESET_PC);
      check("rst_id_pc", ifc.id_pc_o, RESET_PC);
      check("rst_id_instr", ifc.id_instr_o, 0);
      rst = 1'b0;
      in_req = 0;
      in_wait = 0;
      sb.delete();
      req_log.delete();
    end
    ifc.inst_addr_i  = pc;
    ifc.bus_gnt_i    = 1'b0;
    ifc.bus_rvalid_i = 1'b0;
    ifc.flush_i      = 1'b0;
    ifc.bus_rdata_i  = fixed_rdata ? rdata_val : $urandom;
    ifc.id_ready_i   = (int'($urandom_range(99)) < ready_pct);
    if (ifc.bus_req_o && !in_req) begin
      check("req_while_waiting", 32'(in_wait), 0);
      in_req    = 1;
      in_wait   = 0;
      cur_dirty = 0;
      cur_addr  = pc;
      req_log.push_back(pc);
      check("req_addr", ifc.bus_addr_o, pc);
      gnt_wait = $urandom_range(gnt_max, gnt_min);
    end
    if (in_req) begin
      if (gnt_wait == 0) ifc.bus_gnt_i = 1'b1;
      else gnt_wait--;
    end else if (in_wait) begin
      if (rv_wait == 0) ifc.bus_rvalid_i = 1'b1;
      else rv_wait--;
    end
    if (late_rv) begin
      late_rv = 0;
      ifc.bus_rvalid_i = 1'b1;
    end
    if (int'($urandom_range(99)) < flush_pct) begin
      ifc.flush_i  = 1'b1;
      flush_target = $urandom & 32'h0000_fffc;
    end
    if (force_flush) begin
      force_flush = 0;
      ifc.flush_i = 1'b1;
    end
    if (flush_on_rv && in_wait && ifc.bus_rvalid_i) begin
      flush_on_rv = 0;
      ifc.flush_i = 1'b1;
    end
    if (flush_at3 && sb.size() == 3) begin
      flush_at3 = 0;
      ifc.flush_i    = 1'b1;
      ifc.id_ready_i = 1'b1;
    end
    #2;
    if (in_req) begin
      check("req_held", 32'(ifc.bus_req_o), 1);
      check("addr_stable", ifc.bus_addr_o, cur_addr);
      check("pc_incr", 32'(ifc.pc_incr_o), 32'(ifc.bus_gnt_i && !cur_dirty && !ifc.flush_i));
      if (ifc.flush_i) cur_dirty = 1;
      if (ifc.bus_gnt_i) begin
        in_req  = 0;
        in_wait = 1;
        gnt_cnt++;
        rv_wait = $urandom_range(rv_max, rv_min);
      end
    end else begin
      check("pc_incr_outside_req", 32'(ifc.pc_incr_o), 0);
      if (in_wait && ifc.bus_rvalid_i) begin
        if (!cur_dirty && !ifc.flush_i) sb.push_back('{pc: cur_addr, instr: ifc.bus_rdata_i});
        in_wait = 0;
      end else if (in_wait && ifc.flush_i) begin
        cur_dirty = 1;
      end
    end
    if (ifc.flush_i) sb.delete();
    if (sb.size() > DEPTH) check("fifo_overflow", 32'(sb.size()), DEPTH);
    if (ifc.flush_i) pc = flush_target;
    else if (ifc.pc_incr_o) begin
      pc = pc + 32'd4;
      incr_cnt++;
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    pc  = start_pc;
    rst = 1'b1;
    cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        check("id_valid", 32'(ifc.id_valid_o), 32'(sb.size() != 0));
        if (ifc.id_valid_o && ifc.id_ready_i && !ifc.flush_i && sb.size() != 0) begin
          check("id_pc", ifc.id_pc_o, sb[0].pc);
          check("id_instr", ifc.id_instr_o, sb[0].instr);
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    int n, p0, g0, i0, idx;
    rst = 1'b1;
    ifc.inst_addr_i  = '0;
    ifc.bus_gnt_i    = 1'b0;
    ifc.bus_rvalid_i = 1'b0;
    ifc.bus_rdata_i  = '0;
    ifc.flush_i      = 1'b0;
    ifc.id_ready_i   = 1'b0;
    pc = 32'h4;
    flush_target = 32'h100;
    gnt_min = 0; gnt_max = 0; rv_min = 0; rv_max = 0;
    flush_pct = 0; ready_pct = 100;
    fixed_rdata = 1; rdata_val = 32'h0000_0013;

    // 1: single back-to-back fetch
    cycle();
    p0 = pops;
    run(8);
    check("t1_req_count", 32'(req_log.size() > 0), 1);
    if (req_log.size() > 0) check("t1_first_addr", req_log[0], 32'h4);
    check("t1_popped", 32'(pops > p0), 1);

    // 2: fill the FIFO with decode stalled, then drain
    fixed_rdata = 0; ready_pct = 0;
    do_reset(32'h4);
    run(25);
    check("t2_req_count", 32'(req_log.size()), 4);
    check("t2_no_5th_req", 32'(ifc.bus_req_o), 0);
    check("t2_pc_after_fill", pc, 32'h14);
    check("t2_valid_full", 32'(ifc.id_valid_o), 1);
    ready_pct = 100;
    p0 = pops;
    run(20);
    check("t2_drained", 32'(pops - p0 >= 4), 1);
    check("t2_resume_count", 32'(req_log.size() >= 5), 1);
    if (req_log.size() >= 5) check("t2_resume_addr", req_log[4], 32'h14);

    // 3: grant delayed 5 cycles
    gnt_min = 5; gnt_max = 5; rv_max = 1;
    do_reset(32'h40);
    g0 = gnt_cnt; i0 = incr_cnt;
    run(30);
    check("t3_grants", 32'(gnt_cnt - g0 >= 2), 1);
    check("t3_incr_per_grant", 32'(incr_cnt - i0), 32'(gnt_cnt - g0));

    // 4: flush while a request waits for grant
    gnt_min = 3; gnt_max = 3; rv_max = 0;
    do_reset(32'h80);
    n = 0;
    while (!in_req && n < 20) begin cycle(); n++; end
    check("t4_reached_req", 32'(in_req), 1);
    idx = req_log.size();
    flush_target = 32'h100;
    force_flush = 1;
    run(15);
    check("t4_next_req_seen", 32'(req_log.size() > idx), 1);
    if (req_log.size() > idx) check("t4_next_req_addr", req_log[idx], 32'h100);

    // 5a: flush coincident with rvalid
    gnt_min = 0; gnt_max = 1; rv_min = 2; rv_max = 2;
    do_reset(32'h200);
    flush_target = 32'h300;
    flush_on_rv = 1;
    n = 0;
    while (flush_on_rv && n < 30) begin cycle(); n++; end
    check("t5a_flush_hit", 32'(flush_on_rv), 0);
    cycle();
    check("t5a_valid_after", 32'(ifc.id_valid_o), 0);

    // 5b: flush coincident with a pop at count 3
    rv_min = 0; rv_max = 0; ready_pct = 0;
    do_reset(32'h400);
    flush_target = 32'h500;
    flush_at3 = 1;
    n = 0;
    while (flush_at3 && n < 40) begin cycle(); n++; end
    check("t5b_flush_hit", 32'(flush_at3), 0);
    cycle();
    check("t5b_valid_after", 32'(ifc.id_valid_o), 0);

    // 6: reset in WAIT_DATA, then a stray rvalid in IDLE
    ready_pct = 100; rv_min = 6; rv_max = 6;
    do_reset(32'h600);
    n = 0;
    while (!in_wait && n < 20) begin cycle(); n++; end
    check("t6_reached_wait", 32'(in_wait), 1);
    cycle();
    late_rv = 1;
    do_reset(32'h700);
    rv_min = 0; rv_max = 2;
    run(12);
    check("t6_refetch_seen", 32'(req_log.size() > 0), 1);
    if (req_log.size() > 0) check("t6_refetch_addr", req_log[0], 32'h700);

    // random soak
    gnt_min = 0; gnt_max = 3; rv_min = 0; rv_max = 3;
    flush_pct = 4; ready_pct = 60;
    do_reset(32'h1000);
    run(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
